// File: rtl/keypad_entry.sv
`timescale 1ns/1ps
// keypad_entry: 4x4 active-low keypad scanner, debouncer and BCD time entry.
// Optional macro KEYPAD_REPEAT_EN: held digit/backspace keys auto-repeat.
//
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   row_in     keypad rows, active-low (pulled up)
//   col_out    column strobe, active-low one-hot
//   entry_en   1 = entry buffer accepts edits
//   key_valid  one-cycle pulse per accepted key
//   key_code   code of last accepted key
//   hr_t..min_s entry digits 3..0 (hr_t leftmost)
//   entry_done one-cycle pulse, entry committed
//   entry_err  one-cycle pulse, entry rejected
module keypad_entry #(
  parameter logic [15:0] SCAN_DIV       = 16'd5000,
  parameter logic [3:0]  DEBOUNCE_SCANS = 4'd4,
  parameter logic [7:0]  REPEAT_SCANS   = 8'd50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  input  logic       entry_en,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [3:0] hr_t,
  output logic [3:0] hr_s,
  output logic [3:0] min_t,
  output logic [3:0] min_s,
  output logic       entry_done,
  output logic       entry_err
);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD
  } state_t;

  function automatic logic [3:0] key_map(
    input logic [3:0] pos
  );
    logic [3:0] k;
    case (pos)
      4'h0: k = 4'h1;
      4'h1: k = 4'h2;
      4'h2: k = 4'h3;
      4'h3: k = 4'hA;
      4'h4: k = 4'h4;
      4'h5: k = 4'h5;
      4'h6: k = 4'h6;
      4'h7: k = 4'hB;
      4'h8: k = 4'h7;
      4'h9: k = 4'h8;
      4'hA: k = 4'h9;
      4'hB: k = 4'hC;
      4'hC: k = 4'hE;
      4'hD: k = 4'h0;
      4'hE: k = 4'hF;
      4'hF: k = 4'hD;
    endcase
    return k;
  endfunction

  logic [15:0] div_cnt;
  logic [1:0]  col;
  logic [1:0]  col_nx;
  logic        slot_end;

  // per-scan accumulators; count saturates at 2 (= "many")
  logic [1:0]  acc_n;
  logic [3:0]  acc_code;
  logic [1:0]  scan_n;
  logic [3:0]  scan_code;
  logic        eval;

  logic [3:0]  pressed;
  logic [2:0]  hits;
  logic [1:0]  hits_sat;
  logic [1:0]  row_idx;
  logic [2:0]  sum;
  logic [1:0]  sum_sat;
  logic [3:0]  next_code;

  state_t      state;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nx;
  logic [3:0]  cand;

`ifdef KEYPAD_REPEAT_EN
  logic [7:0]  rpt;
  logic [7:0]  rpt_nx;
  logic        rpt_key;
  assign rpt_nx  = rpt + 8'd1;
  assign rpt_key = (cand <= 4'd9) || (cand == 4'hB);
`endif

  assign slot_end = (div_cnt == SCAN_DIV - 16'd1);
  assign col_nx   = col + 2'd1;
  assign cnt_nx   = cnt + 4'd1;

  always_comb begin
    pressed = ~row_in;
    hits = {2'b0, pressed[0]} + {2'b0, pressed[1]}
         + {2'b0, pressed[2]} + {2'b0, pressed[3]};
    hits_sat = (hits > 3'd1) ? 2'd2 : hits[1:0];
    row_idx = 2'd0;
    if (pressed[0])      row_idx = 2'd0;
    else if (pressed[1]) row_idx = 2'd1;
    else if (pressed[2]) row_idx = 2'd2;
    else if (pressed[3]) row_idx = 2'd3;
    sum = {1'b0, acc_n} + {1'b0, hits_sat};
    sum_sat = (sum > 3'd1) ? 2'd2 : sum[1:0];
    next_code = (hits == 3'd1) ? key_map({row_idx, col})
                               : acc_code;
  end

  // column strobe and row sampling
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt   <= 16'd0;
      col       <= 2'd0;
      col_out   <= 4'b1110;
      acc_n     <= 2'd0;
      acc_code  <= 4'd0;
      scan_n    <= 2'd0;
      scan_code <= 4'd0;
      eval      <= 1'b0;
    end else begin
      eval <= 1'b0;
      if (slot_end) begin
        div_cnt <= 16'd0;
        col     <= col_nx;
        col_out <= ~(4'b0001 << col_nx);
        if (col == 2'd3) begin
          scan_n    <= sum_sat;
          scan_code <= next_code;
          acc_n     <= 2'd0;
          acc_code  <= 4'd0;
          eval      <= 1'b1;
        end else begin
          acc_n    <= sum_sat;
          acc_code <= next_code;
        end
      end else begin
        div_cnt <= div_cnt + 16'd1;
      end
    end
  end

  // debounce FSM, one evaluation per full scan
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      cand      <= 4'd0;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
`ifdef KEYPAD_REPEAT_EN
      rpt       <= 8'd0;
`endif
    end else begin
      key_valid <= 1'b0;
      if (eval) begin
        case (state)
          IDLE: begin
            if (scan_n == 2'd1) begin
              cand <= scan_code;
              cnt  <= 4'd1;
              if (DEBOUNCE_SCANS <= 4'd1) begin
                key_valid <= 1'b1;
                key_code  <= scan_code;
                state     <= HELD;
`ifdef KEYPAD_REPEAT_EN
                rpt       <= 8'd0;
`endif
              end else begin
                state <= DEBOUNCE;
              end
            end
          end
          DEBOUNCE: begin
            if (scan_n == 2'd1 && scan_code == cand) begin
              cnt <= cnt_nx;
              if (cnt_nx >= DEBOUNCE_SCANS) begin
                key_valid <= 1'b1;
                key_code  <= cand;
                state     <= HELD;
`ifdef KEYPAD_REPEAT_EN
                rpt       <= 8'd0;
`endif
              end
            end else begin
              state <= IDLE;
            end
          end
          HELD: begin
            if (scan_n == 2'd0) begin
              state <= IDLE;
            end
`ifdef KEYPAD_REPEAT_EN
            else if (rpt_key) begin
              if (rpt_nx >= REPEAT_SCANS) begin
                rpt       <= 8'd0;
                key_valid <= 1'b1;
                key_code  <= cand;
              end else begin
                rpt <= rpt_nx;
              end
            end
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  logic is_digit;
  logic is_bksp;
  logic is_clr;
  logic is_enter;
  logic time_ok;

  assign is_digit = (key_code <= 4'd9);
  assign is_bksp  = (key_code == 4'hB);
  assign is_clr   = (key_code == 4'hC);
  assign is_enter = (key_code == 4'hF);
  assign time_ok  = (min_t <= 4'd5) && (hr_t <= 4'd2);

  // entry buffer, acts the cycle after key_valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hr_t       <= 4'd0;
      hr_s       <= 4'd0;
      min_t      <= 4'd0;
      min_s      <= 4'd0;
      entry_done <= 1'b0;
      entry_err  <= 1'b0;
    end else begin
      entry_done <= 1'b0;
      entry_err  <= 1'b0;
      if (key_valid && entry_en) begin
        unique case (1'b1)
          is_digit: begin
            hr_t  <= hr_s;
            hr_s  <= min_t;
            min_t <= min_s;
            min_s <= key_code;
          end
          is_bksp: begin
            min_s <= min_t;
            min_t <= hr_s;
            hr_s  <= hr_t;
            hr_t  <= 4'd0;
          end
          is_clr: begin
            hr_t  <= 4'd0;
            hr_s  <= 4'd0;
            min_t <= 4'd0;
            min_s <= 4'd0;
          end
          is_enter: begin
            if (time_ok) entry_done <= 1'b1;
            else         entry_err  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
`timescale 1ns/1ps
// tb_keypad_entry: directed bench for keypad_entry with a keypad model.
// SCAN_DIV=4, DEBOUNCE_SCANS=3 -> one scan is 16 cycles.
module tb_keypad_entry;

  logic       clk;
  logic       rst_n;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic       entry_en;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] hr_t;
  logic [3:0] hr_s;
  logic [3:0] min_t;
  logic [3:0] min_s;
  logic       entry_done;
  logic       entry_err;

  keypad_entry #(
    .SCAN_DIV(16'd4),
    .DEBOUNCE_SCANS(4'd3),
    .REPEAT_SCANS(8'd2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .row_in(row_in),
    .col_out(col_out),
    .entry_en(entry_en),
    .key_valid(key_valid),
    .key_code(key_code),
    .hr_t(hr_t),
    .hr_s(hr_s),
    .min_t(min_t),
    .min_s(min_s),
    .entry_done(entry_done),
    .entry_err(entry_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] keys;
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int kv_n = 0;
  int kv_cyc = 0;
  logic [3:0] kv_code = 4'd0;
  int done_n = 0;
  int err_n = 0;
  int both_n = 0;
  logic kv_prev = 1'b0;
  logic [3:0] after_min_s = 4'd0;

  // keypad matrix: a pressed key pulls its row low while its column is strobed
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (kv_prev) after_min_s = min_s;
    kv_prev = key_valid;
    if (key_valid) begin
      kv_n++;
      kv_cyc = cyc;
      kv_code = key_code;
    end
    if (entry_done) done_n++;
    if (entry_err) err_n++;
    if (entry_done && entry_err) both_n++;
  end

  function automatic logic [15:0] kmask(input logic [3:0] code);
    int idx;
    case (code)
      4'h1: idx = 0;
      4'h2: idx = 1;
      4'h3: idx = 2;
      4'hA: idx = 3;
      4'h4: idx = 4;
      4'h5: idx = 5;
      4'h6: idx = 6;
      4'hB: idx = 7;
      4'h7: idx = 8;
      4'h8: idx = 9;
      4'h9: idx = 10;
      4'hC: idx = 11;
      4'hE: idx = 12;
      4'h0: idx = 13;
      4'hF: idx = 14;
      default: idx = 15;
    endcase
    return 16'd1 << idx;
  endfunction

  task automatic align();
    while (cyc % 16 != 0) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] code, input int on, input int off);
    align();
    keys = kmask(code);
    repeat (16 * on) @(negedge clk);
    keys = 16'd0;
    repeat (16 * off) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    do_reset();
    n_checks++;
    if ({key_valid, entry_done, entry_err, key_code,
         hr_t, hr_s, min_t, min_s} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got kv=%b done=%b err=%b code=%h digits=%h%h%h%h, want all 0",
               key_valid, entry_done, entry_err, key_code,
               hr_t, hr_s, min_t, min_s);
    end
    for (int i = 0; i < 40; i++) begin
      exp_col = 4'b0001 << ((cyc / 4) % 4);
      exp_col = ~exp_col;
      n_checks++;
      if (col_out !== exp_col || key_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_scan cyc %0d: col_out=%b kv=%b, want %b kv=0",
                 cyc, col_out, key_valid, exp_col);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_single_key();
    int k0;
    int t0;
    int exp_n;
    int exp_cyc;
    logic [15:0] exp_dig;
`ifdef KEYPAD_REPEAT_EN
    exp_n = 2;
    exp_cyc = 81;
    exp_dig = 16'h0055;
`else
    exp_n = 1;
    exp_cyc = 49;
    exp_dig = 16'h0005;
`endif
    entry_en = 1'b1;
    k0 = kv_n;
    align();
    t0 = cyc;
    keys = kmask(4'h5);
    repeat (16 * 6) @(negedge clk);
    keys = 16'd0;
    repeat (16 * 2) @(negedge clk);
    n_checks++;
    if (kv_n - k0 != exp_n) begin
      n_fail++;
      $display("FAIL single_count: got %0d pulses, want %0d", kv_n - k0, exp_n);
    end
    n_checks++;
    if (kv_code !== 4'h5) begin
      n_fail++;
      $display("FAIL single_code: got %h, want 5", kv_code);
    end
    n_checks++;
    if (kv_cyc != t0 + exp_cyc) begin
      n_fail++;
      $display("FAIL single_time: pulse at cyc %0d, want %0d", kv_cyc, t0 + exp_cyc);
    end
    n_checks++;
    if (after_min_s !== 4'h5) begin
      n_fail++;
      $display("FAIL single_next_cycle: min_s=%h, want 5", after_min_s);
    end
    n_checks++;
    if ({hr_t, hr_s, min_t, min_s} !== exp_dig) begin
      n_fail++;
      $display("FAIL single_digits: got %h%h%h%h, want %h",
               hr_t, hr_s, min_t, min_s, exp_dig);
    end
  endtask

  task automatic test_commit();
    int d0;
    int e0;
    d0 = done_n;
    e0 = err_n;
    press(4'h1, 4, 2);
    press(4'h2, 4, 2);
    press(4'h3, 4, 2);
    press(4'h0, 4, 2);
    n_checks++;
    if ({hr_t, hr_s, min_t, min_s} !== 16'h1230) begin
      n_fail++;
      $display("FAIL commit_digits: got %h%h%h%h, want 1230",
               hr_t, hr_s, min_t, min_s);
    end
    press(4'hF, 4, 2);
    n_checks++;
    if (done_n - d0 != 1 || err_n - e0 != 0) begin
      n_fail++;
      $display("FAIL commit_pulses: done=%0d err=%0d, want 1 0",
               done_n - d0, err_n - e0);
    end
    n_checks++;
    if ({hr_t, hr_s, min_t, min_s} !== 16'h1230) begin
      n_fail++;
      $display("FAIL commit_hold: got %h%h%h%h, want 1230",
               hr_t, hr_s, min_t, min_s);
    end
  endtask

  task automatic test_reject_edit();
    int d0;
    int e0;
    d0 = done_n;
    e0 = err_n;
    press(4'h0, 4, 2);
    press(4'h0, 4, 2);
    press(4'h7, 4, 2);
    press(4'h0, 4, 2);
    press(4'hF, 4, 2);
    n_checks++;
    if (done_n - d0 != 0 || err_n - e0 != 1) begin
      n_fail++;
      $display("FAIL reject_pulses: done=%0d err=%0d, want 0 1",
               done_n - d0, err_n - e0);
    end
    n_checks++;
    if ({hr_t, hr_s, min_t, min_s} !== 16'h0070) begin
      n_fail++;
      $display("FAIL reject_digits: got %h%h%h%h, want 0070",
               hr_t, hr_s, min_t, min_s);
    end
    press(4'hB, 4, 2);
    n_checks++;
    if ({hr_t, hr_s, min_t, min_s} !== 16'h0007) begin
      n_fail++;
      $display("FAIL backspace: got %h%h%h%h, want 0007",
               hr_t, hr_s, min_t, min_s);
    end
    press(4'hC, 4, 2);
    n_checks++;
    if ({hr_t, hr_s, min_t, min_s} !== 16'h0000) begin
      n_fail++;
      $display("FAIL clear: got %h%h%h%h, want 0000",
               hr_t, hr_s, min_t, min_s);
    end
  endtask

  task automatic test_bounce();
    int k0;
    k0 = kv_n;
    align();
    for (int i = 0; i < 16; i++) begin
      keys = (i % 2 == 0) ? kmask(4'h9) : 16'd0;
      repeat (10) @(negedge clk);
    end
    keys = 16'd0;
    repeat (32) @(negedge clk);
    n_checks++;
    if (kv_n != k0) begin
      n_fail++;
      $display("FAIL bounce: got %0d pulses, want 0", kv_n - k0);
    end
    align();
    keys = kmask(4'h1) | kmask(4'h2);
    repeat (16 * 6) @(negedge clk);
    keys = 16'd0;
    repeat (32) @(negedge clk);
    n_checks++;
    if (kv_n != k0) begin
      n_fail++;
      $display("FAIL two_keys: got %0d pulses, want 0", kv_n - k0);
    end
  endtask

  task automatic test_reset_mid();
    int k0;
    int d0;
    int e0;
    entry_en = 1'b1;
    k0 = kv_n;
    align();
    keys = kmask(4'h4);
    repeat (16 * 2 + 4) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (key_valid !== 1'b0 || col_out !== 4'b1110) begin
      n_fail++;
      $display("FAIL in_reset: kv=%b col_out=%b, want 0 1110", key_valid, col_out);
    end
    rst_n = 1'b1;
    repeat (16 * 4) @(negedge clk);
    keys = 16'd0;
    repeat (32) @(negedge clk);
    n_checks++;
    if (kv_n - k0 != 1 || kv_cyc != 49 || kv_code !== 4'h4) begin
      n_fail++;
      $display("FAIL reset_redebounce: pulses=%0d cyc=%0d code=%h, want 1 49 4",
               kv_n - k0, kv_cyc, kv_code);
    end
    n_checks++;
    if ({hr_t, hr_s, min_t, min_s} !== 16'h0004) begin
      n_fail++;
      $display("FAIL reset_digits: got %h%h%h%h, want 0004",
               hr_t, hr_s, min_t, min_s);
    end
    entry_en = 1'b0;
    k0 = kv_n;
    d0 = done_n;
    e0 = err_n;
    press(4'h4, 4, 2);
    press(4'hF, 4, 2);
    n_checks++;
    if (kv_n - k0 != 2 || kv_code !== 4'hF) begin
      n_fail++;
      $display("FAIL disabled_kv: pulses=%0d code=%h, want 2 F", kv_n - k0, kv_code);
    end
    n_checks++;
    if ({hr_t, hr_s, min_t, min_s} !== 16'h0004 ||
        done_n != d0 || err_n != e0) begin
      n_fail++;
      $display("FAIL disabled_frozen: digits %h%h%h%h done=%0d err=%0d, want 0004 0 0",
               hr_t, hr_s, min_t, min_s, done_n - d0, err_n - e0);
    end
  endtask

  task automatic test_hold();
    int k0;
    int t0;
    int exp_n;
    int exp_cyc;
`ifdef KEYPAD_REPEAT_EN
    exp_n = 4;
    exp_cyc = 145;
`else
    exp_n = 1;
    exp_cyc = 49;
`endif
    entry_en = 1'b0;
    k0 = kv_n;
    align();
    t0 = cyc;
    keys = kmask(4'h8);
    repeat (16 * 9) @(negedge clk);
    keys = 16'd0;
    repeat (32) @(negedge clk);
    n_checks++;
    if (kv_n - k0 != exp_n || kv_cyc != t0 + exp_cyc || kv_code !== 4'h8) begin
      n_fail++;
      $display("FAIL hold: pulses=%0d last=%0d code=%h, want %0d %0d 8",
               kv_n - k0, kv_cyc, kv_code, exp_n, t0 + exp_cyc);
    end
    n_checks++;
    if (both_n != 0) begin
      n_fail++;
      $display("FAIL done_and_err: seen together %0d times, want 0", both_n);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    entry_en = 1'b0;
    keys = 16'd0;
    test_reset();
    test_single_key();
    test_commit();
    test_reject_edit();
    test_bounce();
    test_reset_mid();
    test_hold();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
